// File: rtl/parity_frame_checker_pkg.sv
// Shared encodings and sizes for the serial parity frame receiver.
// Frame: start, a[3..0] MSB first, pa, b[3..0] MSB first, pb.
package parity_frame_checker_pkg;

  localparam int NIBBLE_W   = 4;
  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA_A = 3'd1,
    PAR_A  = 3'd2,
    DATA_B = 3'd3,
    PAR_B  = 3'd4
  } rxState_t;

endpackage

// File: rtl/parity_calc4.sv
// XOR reduction of one nibble; combinational, no backpressure.
module parity_calc4
  import parity_frame_checker_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic                parity
);

  assign parity = ^nibble;

endmodule

// File: rtl/parity_frame_checker.sv
// Deserializes start+A+pa+B+pb frames, checks even parity; out_valid 1 cycle after pb strobe.
// Backpressure: frame held while out_ready=0; a frame completing into a full buffer is dropped and flags overrun.
module parity_frame_checker
  import parity_frame_checker_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sin,
  input  logic                 sin_valid,
  output logic [NIBBLE_W-1:0]  out_a,
  output logic [NIBBLE_W-1:0]  out_b,
  output logic                 err_a,
  output logic                 err_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 overrun,
  input  logic                 clear_cnt
);

  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  rxState_t            state, stateNext;
  logic [1:0]          bitCnt;
  logic [NIBBLE_W-1:0] shA, shB;
  logic                paReg;
  logic                frameDone;
  logic                calcA, calcB;
  logic                newErrA, newErrB;
  logic                canLoad, loadFrame, dropFrame, xfer;

  always_comb begin
    stateNext = state;
    frameDone = 1'b0;
    if (sin_valid) begin
      case (state)
        IDLE:    if (sin) stateNext = DATA_A;
        DATA_A:  if (bitCnt == 2'd3) stateNext = PAR_A;
        PAR_A:   stateNext = DATA_B;
        DATA_B:  if (bitCnt == 2'd3) stateNext = PAR_B;
        PAR_B: begin
          stateNext = IDLE;
          frameDone = 1'b1;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // bitCnt wraps 3->0 on its own, so it is already 0 entering each data phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      bitCnt <= 2'd0;
      shA    <= '0;
      shB    <= '0;
      paReg  <= 1'b0;
    end else begin
      state <= stateNext;
      if (sin_valid) begin
        case (state)
          DATA_A: begin
            shA    <= {shA[NIBBLE_W-2:0], sin};
            bitCnt <= bitCnt + 2'd1;
          end
          PAR_A: paReg <= sin;
          DATA_B: begin
            shB    <= {shB[NIBBLE_W-2:0], sin};
            bitCnt <= bitCnt + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  parity_calc4 u_calcA (.nibble(shA), .parity(calcA));
  parity_calc4 u_calcB (.nibble(shB), .parity(calcB));

  // pb is taken straight from the line in the completion cycle
  assign newErrA = calcA ^ paReg;
  assign newErrB = calcB ^ sin;

  assign xfer      = out_valid & out_ready;
  assign canLoad   = ~out_valid | out_ready;
  assign loadFrame = frameDone & canLoad;
  assign dropFrame = frameDone & ~canLoad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a     <= '0;
      out_b     <= '0;
      err_a     <= 1'b0;
      err_b     <= 1'b0;
      out_valid <= 1'b0;
    end else if (loadFrame) begin
      out_a     <= shA;
      out_b     <= shB;
      err_a     <= newErrA;
      err_b     <= newErrB;
      out_valid <= 1'b1;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      overrun <= 1'b0;
    end else if (clear_cnt) begin
      err_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      if (loadFrame && (newErrA || newErrB) && err_cnt != ERR_CNT_MAX)
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      if (dropFrame)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Randomized bench: bit-queue reference model compared against two DUTs (8-bit and 2-bit counters).
module tb_parity_frame_checker;
  import parity_frame_checker_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sin = 1'b0, sin_valid = 1'b0, out_ready = 1'b0, clear_cnt = 1'b0;
  logic [3:0] out_a, out_b, satA, satB;
  logic       err_a, err_b, out_valid, overrun;
  logic       satEa, satEb, satValid, satOvr;
  logic [7:0] err_cnt;
  logic [1:0] satCnt;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  parity_frame_checker dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid),
    .out_a(out_a), .out_b(out_b), .err_a(err_a), .err_b(err_b),
    .out_valid(out_valid), .out_ready(out_ready), .err_cnt(err_cnt),
    .overrun(overrun), .clear_cnt(clear_cnt)
  );

  parity_frame_checker #(.ERR_CNT_W(2)) dutSat (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid),
    .out_a(satA), .out_b(satB), .err_a(satEa), .err_b(satEb),
    .out_valid(satValid), .out_ready(out_ready), .err_cnt(satCnt),
    .overrun(satOvr), .clear_cnt(clear_cnt)
  );

  // Reference model: collected strobed bits since a start bit, plus the output buffer.
  int         mq[$];
  logic       mValid, mEa, mEb, mOvr;
  logic [3:0] mA, mB;
  int         mCnt, mCnt2;

  wire [21:0] obsVec = {out_valid, out_a, out_b, err_a, err_b, overrun, err_cnt, satCnt};

  function automatic logic [21:0] modelVec();
    logic [7:0] c;
    logic [1:0] c2;
    c  = 8'(mCnt);
    c2 = 2'(mCnt2);
    return {mValid, mA, mB, mEa, mEb, mOvr, c, c2};
  endfunction

  function automatic void modelReset();
    mq.delete();
    mValid = 0; mEa = 0; mEb = 0; mOvr = 0;
    mA = 0; mB = 0; mCnt = 0; mCnt2 = 0;
  endfunction

  task automatic step();
    bit   complete = 0;
    int   a = 0, b = 0, pa = 0, pb = 0;
    logic nValid, nEa, nEb, nOvr;
    logic [3:0] nA, nB;
    int   nCnt, nCnt2;
    nValid = mValid; nEa = mEa; nEb = mEb; nOvr = mOvr;
    nA = mA; nB = mB; nCnt = mCnt; nCnt2 = mCnt2;
    if (sin_valid) begin
      if (mq.size() > 0 || sin) mq.push_back(int'(sin));
      complete = (mq.size() == FRAME_BITS);
    end
    if (complete) begin
      a  = mq[1] * 8 + mq[2] * 4 + mq[3] * 2 + mq[4];
      pa = mq[5];
      b  = mq[6] * 8 + mq[7] * 4 + mq[8] * 2 + mq[9];
      pb = mq[10];
      mq.delete();
      if (!mValid || out_ready) begin
        nValid = 1;
        nA = 4'(a); nB = 4'(b);
        nEa = (($countones(a) + pa) % 2) != 0;
        nEb = (($countones(b) + pb) % 2) != 0;
        if (nEa || nEb) begin
          if (nCnt < 255) nCnt++;
          if (nCnt2 < 3) nCnt2++;
        end
      end else begin
        nOvr = 1;
      end
    end else if (mValid && out_ready) begin
      nValid = 0;
    end
    if (clear_cnt) begin
      nCnt = 0; nCnt2 = 0; nOvr = 0;
    end
    @(posedge clk);
    mValid = nValid; mEa = nEa; mEb = nEb; mOvr = nOvr;
    mA = nA; mB = nB; mCnt = nCnt; mCnt2 = nCnt2;
    @(negedge clk);
  endtask

  task automatic sendBit(input logic bitVal, input int gapMax);
    repeat ($urandom_range(gapMax, 0)) begin
      sin_valid = 0;
      sin = 1'($urandom);
      step();
    end
    sin_valid = 1;
    sin = bitVal;
    step();
    sin_valid = 0;
  endtask

  // out_ready/clear_cnt are overridden only for the pb strobe cycle
  task automatic sendFrame(input logic [3:0] a, input logic pa, input logic [3:0] b, input logic pb,
                           input int gapMax, input logic rdyPb, input logic clrPb);
    logic saveR;
    sendBit(1'b1, gapMax);
    for (int i = 3; i >= 0; i--) sendBit(a[i], gapMax);
    sendBit(pa, gapMax);
    for (int i = 3; i >= 0; i--) sendBit(b[i], gapMax);
    repeat ($urandom_range(gapMax, 0)) begin
      sin_valid = 0;
      step();
    end
    saveR = out_ready;
    out_ready = rdyPb;
    clear_cnt = clrPb;
    sin_valid = 1;
    sin = pb;
    step();
    sin_valid = 0;
    out_ready = saveR;
    clear_cnt = 0;
  endtask

  task automatic drain();
    out_ready = 1;
    step();
    out_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    modelReset();
    repeat (2) @(negedge clk);
    nTests++;
    if (obsVec !== 22'd0) begin
      nFail++; $display("FAIL reset_state got %h want 0", obsVec);
    end
    rst_n = 1;
    step();
    nTests++;
    if (obsVec !== modelVec()) begin
      nFail++; $display("FAIL reset_idle got %h want %h", obsVec, modelVec());
    end
  endtask

  task automatic test_clean();
    sendFrame(4'b1011, 1'b1, 4'b0110, 1'b0, 0, 1'b0, 1'b0);
    nTests++;
    if ({out_valid, out_a, out_b, err_a, err_b, err_cnt} !== {1'b1, 4'hB, 4'h6, 2'b00, 8'd0}) begin
      nFail++; $display("FAIL clean_frame got v=%b a=%h b=%h ea=%b eb=%b cnt=%0d want v=1 a=b b=6 ea=0 eb=0 cnt=0",
                        out_valid, out_a, out_b, err_a, err_b, err_cnt);
    end
    drain();
    nTests++;
    if (out_valid !== 1'b0 || obsVec !== modelVec()) begin
      nFail++; $display("FAIL clean_drain got %h want %h", obsVec, modelVec());
    end
  endtask

  task automatic test_parity_err();
    sendFrame(4'b1011, 1'b0, 4'b0110, 1'b0, 0, 1'b0, 1'b0);
    nTests++;
    if ({err_a, err_b, err_cnt} !== {2'b10, 8'd1}) begin
      nFail++; $display("FAIL parity_a got ea=%b eb=%b cnt=%0d want ea=1 eb=0 cnt=1", err_a, err_b, err_cnt);
    end
    drain();
    sendFrame(4'b1011, 1'b1, 4'b0110, 1'b1, 0, 1'b0, 1'b0);
    nTests++;
    if ({err_a, err_b, err_cnt} !== {2'b01, 8'd2} || obsVec !== modelVec()) begin
      nFail++; $display("FAIL parity_b got ea=%b eb=%b cnt=%0d want ea=0 eb=1 cnt=2", err_a, err_b, err_cnt);
    end
    drain();
  endtask

  task automatic test_flow();
    sendFrame(4'h3, 1'b0, 4'hC, 1'b0, 1, 1'b0, 1'b0);
    sendFrame(4'h5, 1'b1, 4'h9, 1'b1, 1, 1'b0, 1'b0);
    nTests++;
    if ({out_valid, out_a, out_b, overrun, err_cnt} !== {1'b1, 4'h3, 4'hC, 1'b1, 8'd2}) begin
      nFail++; $display("FAIL overrun_hold got v=%b a=%h b=%h ovr=%b cnt=%0d want v=1 a=3 b=c ovr=1 cnt=2",
                        out_valid, out_a, out_b, overrun, err_cnt);
    end
    drain();
    nTests++;
    if (out_valid !== 1'b0 || obsVec !== modelVec()) begin
      nFail++; $display("FAIL overrun_drain got %h want %h", obsVec, modelVec());
    end
    clear_cnt = 1;
    step();
    clear_cnt = 0;
    nTests++;
    if ({overrun, err_cnt, satCnt} !== 11'd0) begin
      nFail++; $display("FAIL clear_cnt got ovr=%b cnt=%0d sat=%0d want 0", overrun, err_cnt, satCnt);
    end
  endtask

  task automatic test_back_to_back();
    sendFrame(4'h1, 1'b1, 4'h2, 1'b1, 0, 1'b0, 1'b0);
    sendFrame(4'hE, 1'b1, 4'h7, 1'b1, 0, 1'b1, 1'b0);
    nTests++;
    if ({out_valid, out_a, out_b, overrun} !== {1'b1, 4'hE, 4'h7, 1'b0} || obsVec !== modelVec()) begin
      nFail++; $display("FAIL back_to_back got %h want %h", obsVec, modelVec());
    end
    drain();
  endtask

  task automatic test_gaps();
    repeat (4) sendBit(1'b0, 2);
    sendFrame(4'b1011, 1'b1, 4'b0110, 1'b0, 3, 1'b0, 1'b0);
    nTests++;
    if ({out_valid, out_a, out_b, err_a, err_b} !== {1'b1, 4'hB, 4'h6, 2'b00} || obsVec !== modelVec()) begin
      nFail++; $display("FAIL gaps_frame got %h want %h", obsVec, modelVec());
    end
    sendBit(1'b1, 1);
    for (int i = 0; i < 5; i++) sendBit(1'($urandom), 1);
    rst_n = 0;
    modelReset();
    #1;
    nTests++;
    if (obsVec !== 22'd0) begin
      nFail++; $display("FAIL midframe_reset got %h want 0", obsVec);
    end
    @(negedge clk);
    rst_n = 1;
    sendFrame(4'h9, 1'b0, 4'h4, 1'b1, 1, 1'b0, 1'b0);
    nTests++;
    if ({out_valid, out_a, out_b, err_a, err_b} !== {1'b1, 4'h9, 4'h4, 2'b00} || obsVec !== modelVec()) begin
      nFail++; $display("FAIL after_reset got %h want %h", obsVec, modelVec());
    end
    drain();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) sendFrame(4'(i), 1'b1, 4'hF, 1'b1, 0, 1'b1, 1'b0);
    nTests++;
    if (satCnt !== 2'd3 || obsVec !== modelVec()) begin
      nFail++; $display("FAIL saturate got sat=%0d cnt=%0d want sat=3 cnt=%0d", satCnt, err_cnt, mCnt);
    end
    sendFrame(4'h6, 1'b1, 4'h1, 1'b0, 0, 1'b1, 1'b1);
    nTests++;
    if ({out_valid, out_a, err_a, err_b, err_cnt, satCnt} !== {1'b1, 4'h6, 2'b11, 8'd0, 2'd0}) begin
      nFail++; $display("FAIL clear_wins got v=%b a=%h ea=%b eb=%b cnt=%0d sat=%0d want v=1 a=6 ea=1 eb=1 cnt=0 sat=0",
                        out_valid, out_a, err_a, err_b, err_cnt, satCnt);
    end
    drain();
  endtask

  task automatic test_random();
    for (int f = 0; f < 30; f++) begin
      out_ready = 1'($urandom);
      if ($urandom_range(3, 0) == 0) sendBit(1'b0, 2);
      sendFrame(4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), $urandom_range(2, 0),
                1'($urandom), ($urandom_range(9, 0) == 0));
      nTests++;
      if (obsVec !== modelVec()) begin
        nFail++; $display("FAIL random_frame_%0d got %h want %h", f, obsVec, modelVec());
      end
    end
    out_ready = 0;
  endtask

  initial begin
    modelReset();
    test_reset();
    test_clean();
    test_parity_err();
    test_flow();
    test_back_to_back();
    test_gaps();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
